// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: FSM encoding and per-operation cycle counts shared by sram_ctrl.
// SRAM_CTRL_VERIFY_EN adds the verify-read states VF_ADDR/VF_CAP.
package sram_ctrl_pkg;

  localparam int SRAM_DW    = 8;
  localparam int WR_CYCLES  = 4;
  localparam int RD_CYCLES  = 3;
  localparam int WRV_CYCLES = 6;

  typedef enum logic [2:0] {
    IDLE,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    RD_ADDR,
    RD_CAP
`ifdef SRAM_CTRL_VERIFY_EN
    ,
    VF_ADDR,
    VF_CAP
`endif
  } state_t;

  // Accept-to-rsp_valid latency of an operation in the current build.
  function automatic int op_cycles(logic we);
    int wr;
    wr = WR_CYCLES;
`ifdef SRAM_CTRL_VERIFY_EN
    wr = WRV_CYCLES;
`endif
    return we ? wr : RD_CYCLES;
  endfunction

endpackage

// File: rtl/sram_ctrl_if.sv
// sram_ctrl_if: host request/response handshake of sram_ctrl.
interface sram_ctrl_if
  import sram_ctrl_pkg::*;
#(
  parameter int Width = 5
) ();

  logic               req_valid;
  logic               req_ready;
  logic               req_we;
  logic [Width-1:0]   req_addr;
  logic [SRAM_DW-1:0] req_wdata;
  logic               rsp_valid;
  logic [SRAM_DW-1:0] rsp_rdata;
  logic               rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/sram_ctrl_iobuf.sv
// sram_ctrl_iobuf: tri-state driver/receiver for the shared SRAM data bus.
module sram_ctrl_iobuf
  import sram_ctrl_pkg::*;
(
  input  logic               oe,
  input  logic [SRAM_DW-1:0] dout,
  output logic [SRAM_DW-1:0] din,
  inout  wire  [SRAM_DW-1:0] pad
);

  assign pad = oe ? dout : {SRAM_DW{1'bz}};
  assign din = pad;

endmodule

// File: rtl/sram_ctrl.sv
// sram_ctrl: one-request-at-a-time controller for an asynchronous single-port SRAM.
// Define SRAM_CTRL_VERIFY_EN to read back and compare every written word.
//
// state    | meaning
// IDLE     | ready for a request; first IDLE cycle after an op carries rsp_valid
// WR_SETUP | address/data driven, strobe low
// WR_PULSE | sram_write high, SRAM captures on its rising edge
// WR_HOLD  | address/data held after strobe falls
// RD_ADDR  | output enable on, SRAM data settling
// RD_CAP   | read data captured at exit edge
// VF_ADDR  | verify read of the written address
// VF_CAP   | verify data compared with written data at exit edge
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int Width = 5,
  parameter int Max   = 1 << Width
) (
  input  logic               clk,
  input  logic               rst_n,
  sram_ctrl_if.slave         bus,
  output logic               sram_read,
  output logic               sram_write,
  output logic [Width-1:0]   sram_addr,
  inout  wire  [SRAM_DW-1:0] sram_data
);

  state_t             state, state_nxt;
  logic [Width-1:0]   addr_q;
  logic [SRAM_DW-1:0] wdata_q, rdata_q, din;
  logic               ready_en, done_q, drive, accept, last_cyc;

  if (Max > (1 << Width)) begin : g_max_check
    $error("sram_ctrl: Max exceeds the address space of Width bits");
  end

  assign accept = bus.req_valid && bus.req_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (accept) state_nxt = bus.req_we ? WR_SETUP : RD_ADDR;
      WR_SETUP: state_nxt = WR_PULSE;
      WR_PULSE: state_nxt = WR_HOLD;
`ifdef SRAM_CTRL_VERIFY_EN
      WR_HOLD:  state_nxt = VF_ADDR;
      VF_ADDR:  state_nxt = VF_CAP;
      VF_CAP:   state_nxt = IDLE;
`else
      WR_HOLD:  state_nxt = IDLE;
`endif
      RD_ADDR:  state_nxt = RD_CAP;
      RD_CAP:   state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sram_read     = 1'b0;
    sram_write    = 1'b0;
    drive         = 1'b0;
    last_cyc      = 1'b0;
    bus.req_ready = 1'b0;
    unique case (state)
      IDLE:     bus.req_ready = ready_en;
      WR_SETUP: drive = 1'b1;
      WR_PULSE: begin
        drive      = 1'b1;
        sram_write = 1'b1;
      end
      WR_HOLD: begin
        drive = 1'b1;
`ifndef SRAM_CTRL_VERIFY_EN
        last_cyc = 1'b1;
`endif
      end
      RD_ADDR:  sram_read = 1'b1;
      RD_CAP: begin
        sram_read = 1'b1;
        last_cyc  = 1'b1;
      end
`ifdef SRAM_CTRL_VERIFY_EN
      VF_ADDR:  sram_read = 1'b1;
      VF_CAP: begin
        sram_read = 1'b1;
        last_cyc  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // ready_en keeps req_ready low for the cycle that follows a reset edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      ready_en <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      done_q   <= last_cyc;
      if (accept) begin
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      if (state == RD_CAP) rdata_q <= din;
    end
  end

`ifdef SRAM_CTRL_VERIFY_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (!rst_n)                err_q <= 1'b0;
    else if (state == VF_CAP)  err_q <= (din != wdata_q);
  end
  assign bus.rsp_err = err_q;
`else
  assign bus.rsp_err = 1'b0;
`endif

  assign bus.rsp_valid = done_q;
  assign bus.rsp_rdata = rdata_q;
  assign sram_addr     = addr_q;

  sram_ctrl_iobuf u_io (
    .oe   (drive),
    .dout (wdata_q),
    .din  (din),
    .pad  (sram_data)
  );

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: directed vectors plus a cycle-level reference model for sram_ctrl.
module tb_sram_ctrl;
  import sram_ctrl_pkg::*;

  localparam int W = 5;
`ifdef SRAM_CTRL_VERIFY_EN
  localparam int WR_LAT  = 6;
  localparam int WR_LAST = 5;
`else
  localparam int WR_LAT  = 4;
  localparam int WR_LAST = 3;
`endif
  localparam int RD_LAT = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         sram_read, sram_write;
  logic [W-1:0] sram_addr;
  wire  [7:0]   sram_data;

  sram_ctrl_if #(.Width(W)) bus ();

  sram_ctrl #(.Width(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .sram_read  (sram_read),
    .sram_write (sram_write),
    .sram_addr  (sram_addr),
    .sram_data  (sram_data)
  );

  always #5 clk = ~clk;

  // SRAM model; corrupt flips bit0 when 8'h55 is written
  logic [7:0] mem [32] = '{default: 8'h00};
  logic       corrupt = 1'b0;
  assign sram_data = sram_read ? mem[sram_addr] : 8'bz;
  always @(posedge sram_write)
    mem[sram_addr] <= (corrupt && sram_data == 8'h55) ? (sram_data ^ 8'h01) : sram_data;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: op 0=none 1=write 2=read, ph = cycle index since accept
  int           m_op = 0, m_ph = 0;
  logic         m_rdy = 1'b0, m_vld = 1'b0, mon_en = 1'b0, m_err = 1'b0;
  logic [W-1:0] m_addr = '0;
  logic [7:0]   m_wdata = '0, m_rdata = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_op = 0; m_ph = 0; m_rdy = 1'b0; m_vld = 1'b0; m_err = 1'b0;
      m_addr = '0; m_wdata = '0; m_rdata = '0; mon_en = 1'b1;
    end else begin
      m_vld = 1'b0;
      if (m_op != 0) begin
        if (m_ph == ((m_op == 1) ? WR_LAST : 2)) begin
          m_vld = 1'b1;
          if (m_op == 2) m_rdata = mem[m_addr];
`ifdef SRAM_CTRL_VERIFY_EN
          else m_err = (mem[m_addr] != m_wdata);
`endif
          m_op = 0; m_ph = 0;
        end else m_ph++;
      end else if (m_rdy && bus.req_valid) begin
        m_op = bus.req_we ? 1 : 2; m_ph = 1;
        m_addr = bus.req_addr; m_wdata = bus.req_wdata;
      end
      m_rdy = 1'b1;
    end
  end

  always @(negedge clk) if (mon_en) begin
    chk("req_ready", bus.req_ready, m_op == 0 && m_rdy);
    chk("rsp_valid", bus.rsp_valid, m_vld);
    chk("sram_write", sram_write, m_op == 1 && m_ph == 2);
    chk("sram_read", sram_read, m_op == 2 || (m_op == 1 && m_ph >= 4));
    chk("bus_drive", dut.u_io.oe, m_op == 1 && m_ph <= 3);
    chk("sram_addr", sram_addr, m_addr);
    chk("rsp_rdata", bus.rsp_rdata, m_rdata);
    chk("rsp_err", bus.rsp_err, m_err);
    chk("rd_wr_excl", sram_read && sram_write, 0);
    chk("rd_vs_drive", sram_read && dut.u_io.oe, 0);
    if (m_op == 1 && m_ph <= 3) chk("wr_data", sram_data, m_wdata);
  end

  task automatic do_op(input string nm, input logic we, input logic [W-1:0] a,
                       input logic [7:0] d, input int exp_lat, input logic [7:0] exp_rd,
                       input logic exp_err);
    int n;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = a; bus.req_wdata = d;
    n = 0;
    while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
    chk({nm, "_accept"}, n < 20, 1);
    @(posedge clk);
    @(negedge clk);
    // fields scrambled while busy must be ignored
    bus.req_valid = 1'b0; bus.req_we = ~we; bus.req_addr = ~a; bus.req_wdata = ~d;
    n = 1;
    while (!bus.rsp_valid && n < 12) begin @(negedge clk); n++; end
    chk({nm, "_latency"}, n, exp_lat);
    chk({nm, "_rdata"}, bus.rsp_rdata, exp_rd);
    chk({nm, "_err"}, bus.rsp_err, exp_err);
  endtask

  typedef struct {
    logic         we;
    logic [W-1:0] addr;
    logic [7:0]   wdata;
    int           lat;
    logic [7:0]   rdata;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int n;
    vecs[0] = '{1'b1, 5'h03, 8'hA5, WR_LAT, 8'h00};
    vecs[1] = '{1'b0, 5'h03, 8'h00, RD_LAT, 8'hA5};
    vecs[2] = '{1'b1, 5'h00, 8'h11, WR_LAT, 8'hA5};
    vecs[3] = '{1'b1, 5'h1F, 8'h22, WR_LAT, 8'hA5};
    vecs[4] = '{1'b0, 5'h00, 8'h00, RD_LAT, 8'h11};
    vecs[5] = '{1'b0, 5'h1F, 8'h00, RD_LAT, 8'h22};
    vecs[6] = '{1'b1, 5'h00, 8'hFF, WR_LAT, 8'h22};
    vecs[7] = '{1'b0, 5'h00, 8'h00, RD_LAT, 8'hFF};
    vecs[8] = '{1'b0, 5'h03, 8'h00, RD_LAT, 8'hA5};

    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_valid", bus.rsp_valid, 0);
    chk("rst_rdata", bus.rsp_rdata, 0);
    chk("rst_addr", sram_addr, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", bus.req_ready, 1);

    for (int i = 0; i < 9; i++)
      do_op($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
            vecs[i].lat, vecs[i].rdata, 1'b0);

    // back-to-back: read 1F, then write 1F with req_valid held through the response cycle
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 5'h1F; bus.req_wdata = 8'h00;
    n = 0;
    while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
    chk("b2b_accept1", n < 20, 1);
    @(posedge clk);
    @(negedge clk);
    bus.req_we = 1'b1; bus.req_wdata = 8'h3C;
    n = 1;
    while (!bus.rsp_valid && n < 12) begin @(negedge clk); n++; end
    chk("b2b_rd_latency", n, RD_LAT);
    chk("b2b_rd_rdata", bus.rsp_rdata, 8'h22);
    chk("b2b_ready_in_rsp", bus.req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    n = 1;
    while (!bus.rsp_valid && n < 12) begin @(negedge clk); n++; end
    chk("b2b_wr_latency", n, WR_LAT);
    do_op("b2b_readback", 1'b0, 5'h1F, 8'h00, RD_LAT, 8'h3C, 1'b0);

    // reset during WR_PULSE: word stays written, no response
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 5'h09; bus.req_wdata = 8'h77;
    n = 0;
    while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
    chk("abort_accept", n < 20, 1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("abort_in_pulse", sram_write, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_ready", bus.req_ready, 0);
    chk("abort_valid", bus.rsp_valid, 0);
    chk("abort_write", sram_write, 0);
    chk("abort_read", sram_read, 0);
    chk("abort_drive", dut.u_io.oe, 0);
    chk("abort_addr", sram_addr, 0);
    chk("abort_rdata", bus.rsp_rdata, 0);
    chk("abort_err", bus.rsp_err, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ready_back", bus.req_ready, 1);
    chk("abort_no_valid", bus.rsp_valid, 0);
    do_op("abort_readback", 1'b0, 5'h09, 8'h00, RD_LAT, 8'h77, 1'b0);

`ifdef SRAM_CTRL_VERIFY_EN
    corrupt = 1'b1;
    do_op("vf_bad", 1'b1, 5'h0A, 8'h55, WR_LAT, 8'h77, 1'b1);
    do_op("vf_good", 1'b1, 5'h0B, 8'h5A, WR_LAT, 8'h77, 1'b0);
    corrupt = 1'b0;
    do_op("vf_readback", 1'b0, 5'h0A, 8'h00, RD_LAT, 8'h54, 1'b0);
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 SHALL have parameter Width, default 5, address width in bits.
REQ-002 SHALL have parameter Max, default 1<<Width, number of addressable words.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-005 SHALL have port req_valid, input, 1, host request present.
REQ-006 SHALL have port req_ready, output, 1, controller can accept a request.
REQ-007 SHALL have port req_we, input, 1, 1=write, 0=read.
REQ-008 SHALL have port req_addr, input, Width, target word address.
REQ-009 SHALL have port req_wdata, input, 8, write data.
REQ-010 SHALL have port rsp_valid, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port rsp_rdata, output, 8, read data; valid when rsp_valid follows a read.
REQ-012 SHALL have port rsp_err, output, 1, write-verify mismatch flag; valid with rsp_valid.
REQ-013 SHALL have port sram_read, output, 1, SRAM output enable.
REQ-014 SHALL have port sram_write, output, 1, SRAM write strobe; the SRAM captures on its rising edge.
REQ-015 SHALL have port sram_addr, output, Width, SRAM address.
REQ-016 SHALL have port sram_data, inout, 8, shared SRAM data bus.

Function
REQ-017 SHALL use FSM states IDLE, WR_SETUP, WR_PULSE, WR_HOLD, RD_ADDR and RD_CAP (plus VF_ADDR and VF_CAP, see Configuration).
REQ-018 SHALL assert req_ready only in IDLE; a request is accepted on an edge where req_valid && req_ready, and req_addr/req_we/req_wdata are registered at that edge.
REQ-019 SHALL sequence a write as IDLE->WR_SETUP->WR_PULSE->WR_HOLD->IDLE, one cycle each.
REQ-020 SHALL drive, during a write, sram_addr and sram_data in all three WR states, with sram_write=1 only in WR_PULSE.
REQ-021 SHALL sequence a read as IDLE->RD_ADDR->RD_CAP->IDLE, with sram_read=1 in both states.
REQ-022 SHALL load rsp_rdata from sram_data at the RD_CAP->IDLE edge; the SRAM output delay is 1ns, so clk period SHALL be >=10ns.
REQ-023 SHALL pulse rsp_valid for exactly the first IDLE cycle after an operation.
REQ-024 SHALL give latency from the accept edge to rsp_valid high of 4 cycles for a write and 3 cycles for a read (6 for a write with verify).
REQ-025 SHALL hold rsp_rdata until the next read completes; writes leave it unchanged.
REQ-026 SHALL drive sram_data only in WR states and keep it high-Z otherwise.
REQ-027 SHALL never assert sram_read and sram_write together, and SHALL never assert sram_read while driving sram_data.
REQ-028 SHALL accept a new request in the IDLE cycle where rsp_valid=1 (back-to-back allowed); this IDLE cycle is the mandatory bus-turnaround cycle after a read.
REQ-029 SHALL ignore req_valid in non-IDLE states; there is no queueing and request fields may change freely while req_ready=0.
REQ-030 SHALL drive sram_addr from the registered address, holding it in IDLE.
REQ-031 SHALL wrap addresses naturally within Width bits; there is no range check.

Reset
REQ-032 SHALL, on rst_n=0 at a rising clk edge, enter IDLE with req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, sram_read=0, sram_write=0, sram_addr=0 and sram_data high-Z.
REQ-033 SHALL raise req_ready in the first cycle after rst_n is sampled high.
REQ-034 SHALL abort any in-flight operation on reset with no rsp_valid; if the abort occurs after WR_PULSE, the SRAM word is already written and stays written.

Configuration
REQ-035 SHALL, with macro SRAM_CTRL_VERIFY_EN defined, follow WR_HOLD with VF_ADDR->VF_CAP (read of the same address), compare the captured data with the written data, and set rsp_err=1 on mismatch and 0 on match; rsp_rdata is not updated by a verify read.
REQ-036 SHALL, without SRAM_CTRL_VERIFY_EN, omit the VF states entirely, go WR_HOLD->IDLE, and tie rsp_err to 0.

Structure
REQ-037 SHALL place the FSM state enum, the SRAM_DW=8 constant and the per-operation cycle-count constants in shared package sram_ctrl_pkg.
REQ-038 SHALL implement the tri-state sram_data driver/receiver as one sub-module, sram_ctrl_iobuf (inputs oe and dout, output din, inout pad).

Verification
REQ-039 SHALL cover: write addr 5'h03 data 8'hA5 -> sram_write pulse exactly 1 cycle with sram_data=8'hA5 and sram_addr=5'h03 stable from WR_SETUP to WR_HOLD; rsp_valid on the 4th cycle after accept.
REQ-040 SHALL cover: read 5'h03 after that write -> rsp_rdata=8'hA5 with rsp_valid on the 3rd cycle after accept; sram_data never driven by the DUT.
REQ-041 SHALL cover: back-to-back read 5'h1F then write 5'h1F 8'h3C with req_valid held -> second accept in the rsp_valid cycle; no cycle with sram_read=1 while the DUT drives the bus; a subsequent read returns 8'h3C.
REQ-042 SHALL cover: rst_n=0 during WR_PULSE -> next cycle all outputs at reset values, no rsp_valid, sram_data high-Z.
REQ-043 SHALL cover (verify build only): SRAM model forced to corrupt bit0 on write of 8'h55 -> rsp_err=1 with rsp_valid on the 6th cycle after accept; an uncorrupted write gives rsp_err=0.
REQ-044 SHALL check on every cycle that sram_read && sram_write is never 1 and that req_ready=0 outside IDLE.
